// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage.
//
// Issues a single fetch at a time to the instruction memory port, buffers the
// returned word with its PC, and chooses the next PC by static branch
// prediction. The PC of the path that prediction did not take is carried
// alongside the instruction so that EX can recover from a misprediction.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-high reset
//   stall_signal[4:0]     pipeline stall vector; bit 2 holds IF/ID
//   jump_flag             redirect/flush from EX
//   jump_target_i[31:0]   redirect PC, valid with jump_flag
//   mem_req_o             fetch request
//   mem_addr_o[31:0]      fetch address (current PC)
//   mem_ready_i           request accepted this cycle
//   mem_valid_i           returned instruction valid
//   mem_data_i[31:0]      returned instruction word
//   pc_o[31:0]            PC of buffered instruction
//   inst_o[31:0]          buffered instruction
//   without_prediction_o  alternate (non-predicted) next PC
//   if_stall_req          no valid instruction presented this cycle
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  stall_signal,
    input  logic        jump_flag,
    input  logic [31:0] jump_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] without_prediction_o,
    output logic        if_stall_req
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic        drop_r, drop_nxt_s;
    logic [31:0] buf_pc_r, buf_pc_nxt_s;
    logic [31:0] buf_inst_r, buf_inst_nxt_s;
    logic [31:0] buf_alt_r, buf_alt_nxt_s;

    logic        mem_req_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_b_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pred_s;
    logic [31:0] alt_s;
    logic        unused_s;

    // Only the IF/ID hold bit of the stall vector matters to this stage.
    assign unused_s = ^{stall_signal[4:3], stall_signal[1:0]};

    // Request decode; nothing is issued during reset or in a redirect cycle.
    assign mem_req_s  = (state_r == ST_IDLE) && !jump_flag && !rst;
    assign mem_req_o  = mem_req_s;
    assign mem_addr_o = pc_r;

    // Buffered instruction is only presented while in HOLD.
    assign pc_o                 = (state_r == ST_HOLD) ? buf_pc_r   : 32'h0000_0000;
    assign inst_o               = (state_r == ST_HOLD) ? buf_inst_r : 32'h0000_0000;
    assign without_prediction_o = (state_r == ST_HOLD) ? buf_alt_r  : 32'h0000_0000;
    assign if_stall_req         = (state_r != ST_HOLD);

    // RV32I J- and B-type immediates, sign-extended.
    assign imm_j_s = {{12{mem_data_i[31]}}, mem_data_i[19:12], mem_data_i[20],
                      mem_data_i[30:21], 1'b0};
    assign imm_b_s = {{20{mem_data_i[31]}}, mem_data_i[7], mem_data_i[30:25],
                      mem_data_i[11:8], 1'b0};
    assign pc_plus4_s = pc_r + 32'd4;

    // Static prediction: JAL and backward branches taken, everything else
    // (including JALR, whose target is unknown here) falls through.
    always_comb begin
        pred_s = pc_plus4_s;
        alt_s  = pc_plus4_s;
        if (mem_data_i[6:0] == OP_JAL) begin
            pred_s = pc_r + imm_j_s;
        end else if (mem_data_i[6:0] == OP_BRANCH) begin
            if (imm_b_s[31]) begin
                pred_s = pc_r + imm_b_s;
            end else begin
                alt_s = pc_r + imm_b_s;
            end
        end else begin
            pred_s = pc_plus4_s;
        end
    end

    // Next-state and datapath update; a redirect overrides every other event.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        drop_nxt_s     = drop_r;
        buf_pc_nxt_s   = buf_pc_r;
        buf_inst_nxt_s = buf_inst_r;
        buf_alt_nxt_s  = buf_alt_r;
        if (jump_flag) begin
            pc_nxt_s       = jump_target_i;
            buf_pc_nxt_s   = 32'h0000_0000;
            buf_inst_nxt_s = 32'h0000_0000;
            buf_alt_nxt_s  = 32'h0000_0000;
            case (state_r)
                ST_WAIT: begin
                    // The in-flight response must still be drained.
                    if (mem_valid_i) begin
                        state_nxt_s = ST_IDLE;
                        drop_nxt_s  = 1'b0;
                    end else begin
                        drop_nxt_s  = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    drop_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_req_s && mem_ready_i) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid_i && drop_r) begin
                        drop_nxt_s  = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else if (mem_valid_i) begin
                        buf_pc_nxt_s   = pc_r;
                        buf_inst_nxt_s = mem_data_i;
                        buf_alt_nxt_s  = alt_s;
                        pc_nxt_s       = pred_s;
                        state_nxt_s    = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall_signal[2]) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            drop_r     <= 1'b0;
            buf_pc_r   <= 32'h0000_0000;
            buf_inst_r <= 32'h0000_0000;
            buf_alt_r  <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            drop_r     <= drop_nxt_s;
            buf_pc_r   <= buf_pc_nxt_s;
            buf_inst_r <= buf_inst_nxt_s;
            buf_alt_r  <= buf_alt_nxt_s;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  stall_signal;
    logic        jump_flag;
    logic [31:0] jump_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] without_prediction_o;
    logic        if_stall_req;

    int n_checks;
    int n_pass;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_signal         (stall_signal),
        .jump_flag            (jump_flag),
        .jump_target_i        (jump_target_i),
        .mem_req_o            (mem_req_o),
        .mem_addr_o           (mem_addr_o),
        .mem_ready_i          (mem_ready_i),
        .mem_valid_i          (mem_valid_i),
        .mem_data_i           (mem_data_i),
        .pc_o                 (pc_o),
        .inst_o               (inst_o),
        .without_prediction_o (without_prediction_o),
        .if_stall_req         (if_stall_req)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, accept it, return data
    // the next cycle and leave the stage in HOLD.
    task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        int waited;
        waited = 0;
        while (!mem_req_o && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
        check_eq({tag, "_addr"}, mem_addr_o, exp_addr);
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        check_eq({tag, "_wait_req"}, {31'd0, mem_req_o}, 32'd0);
        mem_valid_i = 1'b1;
        mem_data_i  = data;
        @(negedge clk);
        mem_valid_i = 1'b0;
        mem_data_i  = 32'h0000_0000;
        check_eq({tag, "_hold"}, {31'd0, if_stall_req}, 32'd0);
    endtask

    task automatic check_hold(input string tag, input logic [31:0] epc,
                              input logic [31:0] einst, input logic [31:0] ealt);
        check_eq({tag, "_pc"}, pc_o, epc);
        check_eq({tag, "_inst"}, inst_o, einst);
        check_eq({tag, "_alt"}, without_prediction_o, ealt);
    endtask

    task automatic redirect(input logic [31:0] target);
        jump_flag     = 1'b1;
        jump_target_i = target;
        #1;
        check_eq("jump_no_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        jump_flag     = 1'b0;
        jump_target_i = 32'h0000_0000;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        stall_signal  = 5'b00000;
        jump_flag     = 1'b0;
        jump_target_i = 32'h0000_0000;
        mem_ready_i   = 1'b0;
        mem_valid_i   = 1'b0;
        mem_data_i    = 32'h0000_0000;

        // Reset state.
        @(negedge clk);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_inst", inst_o, 32'h0);
        check_eq("rst_alt", without_prediction_o, 32'h0);
        check_eq("rst_stall", {31'd0, if_stall_req}, 32'd1);
        check_eq("rst_req", {31'd0, mem_req_o}, 32'd0);
        rst = 1'b0;

        // Plain addi at 0.
        fetch("addi", 32'h0, 32'h0000_0013);
        check_hold("addi", 32'h0, 32'h0000_0013, 32'h4);
        @(negedge clk);
        check_eq("addi_next_addr", mem_addr_o, 32'h4);

        // Backward beq at 0x100, imm -4.
        redirect(32'h100);
        fetch("bwd", 32'h100, 32'hFE00_0EE3);
        check_hold("bwd", 32'h100, 32'hFE00_0EE3, 32'h104);
        @(negedge clk);
        check_eq("bwd_next_addr", mem_addr_o, 32'hFC);

        // Forward JAL at 0x20, imm +16.
        redirect(32'h20);
        fetch("jal", 32'h20, 32'h0100_006F);
        check_hold("jal", 32'h20, 32'h0100_006F, 32'h24);
        @(negedge clk);
        check_eq("jal_next_addr", mem_addr_o, 32'h30);

        // Forward beq at 0x40, imm +8.
        redirect(32'h40);
        fetch("fwd", 32'h40, 32'h0000_0463);
        check_hold("fwd", 32'h40, 32'h0000_0463, 32'h48);
        @(negedge clk);
        check_eq("fwd_next_addr", mem_addr_o, 32'h44);

        // IF/ID hold for 4 cycles while in HOLD.
        fetch("stall", 32'h44, 32'h0000_0013);
        stall_signal = 5'b00100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_hold("stall_hold", 32'h44, 32'h0000_0013, 32'h48);
            check_eq("stall_no_req", {31'd0, mem_req_o}, 32'd0);
            check_eq("stall_valid", {31'd0, if_stall_req}, 32'd0);
        end
        stall_signal = 5'b00000;
        @(negedge clk);
        check_eq("release_req", {31'd0, mem_req_o}, 32'd1);
        check_eq("release_addr", mem_addr_o, 32'h48);

        // Redirect while WAIT; late response must be dropped.
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        jump_flag     = 1'b1;
        jump_target_i = 32'h200;
        @(negedge clk);
        jump_flag     = 1'b0;
        jump_target_i = 32'h0000_0000;
        @(negedge clk);
        check_eq("drop_wait_req", {31'd0, mem_req_o}, 32'd0);
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h0000_0013;
        @(negedge clk);
        mem_valid_i = 1'b0;
        mem_data_i  = 32'h0000_0000;
        check_eq("drop_no_hold", {31'd0, if_stall_req}, 32'd1);
        check_eq("drop_inst", inst_o, 32'h0);
        check_eq("drop_req", {31'd0, mem_req_o}, 32'd1);
        check_eq("drop_addr", mem_addr_o, 32'h200);

        // Reset asserted mid-WAIT.
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req", {31'd0, mem_req_o}, 32'd0);
        check_eq("arst_addr", mem_addr_o, 32'h0);
        check_eq("arst_stall", {31'd0, if_stall_req}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_valid_i = 1'b0;
        mem_data_i  = 32'h0000_0000;
        check_eq("late_valid_stall", {31'd0, if_stall_req}, 32'd1);
        check_eq("late_valid_inst", inst_o, 32'h0);
        fetch("post_rst", 32'h0, 32'h0000_0013);
        check_hold("post_rst", 32'h0, 32'h0000_0013, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipeline; the producer that feeds the IF/ID register its pc, inst and without_prediction values.
- Issues one instruction fetch at a time to the memory/icache port and buffers the returned word.
- Applies static branch prediction to choose the next PC and records the alternate (non-predicted) PC for later misprediction recovery.
- Honours back-pressure from stall_signal and redirects on jump_flag.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- stall_signal  input  5  pipeline stall vector; bit 2 = IF/ID hold (output must not be consumed).
- jump_flag  input  1  redirect/flush from EX, same signal that clears IF/ID.
- jump_target_i  input  32  redirect PC, valid when jump_flag=1.
- mem_req_o  output  1  fetch request.
- mem_addr_o  output  32  fetch address (word-aligned PC).
- mem_ready_i  input  1  request accepted this cycle.
- mem_valid_i  input  1  returned instruction valid.
- mem_data_i  input  32  returned instruction word.
- pc_o  output  32  PC of buffered instruction, to IF/ID pc_i.
- inst_o  output  32  buffered instruction, to IF/ID inst_i.
- without_prediction_o  output  32  alternate PC (path not taken by prediction).
- if_stall_req  output  1  no valid instruction this cycle; controller turns this into stall_signal[1] (IF/ID bubble).

Behaviour:
- Registers: pc, state {IDLE, WAIT, HOLD}, drop flag, buffer (pc, inst, alt).
- Reset (async, any state): pc=RESET_PC, state=IDLE, drop=0, buffer cleared to 0.
  - After reset: pc_o, inst_o and without_prediction_o are 0; if_stall_req=1; mem_req_o=0 until the first clock with rst low.
- Output decode:
  - mem_req_o = (state==IDLE) && !jump_flag; mem_addr_o = pc.
  - pc_o, inst_o, without_prediction_o are driven from the buffer registers; all zero when state!=HOLD.
  - if_stall_req = (state!=HOLD).
- Transitions (jump_flag=0):
  - IDLE: when mem_req_o && mem_ready_i, go to WAIT.
  - WAIT, mem_valid_i, drop=1: discard data, clear drop, go to IDLE.
  - WAIT, mem_valid_i, drop=0: buffer <= {pc, mem_data_i, alt}; pc <= pred; go to HOLD.
  - HOLD, stall_signal[2]=0: instruction consumed by IF/ID at this edge; go to IDLE.
  - HOLD, stall_signal[2]=1: hold all buffer and pc values unchanged.
- jump_flag=1 (highest priority after rst):
  - pc <= jump_target_i; buffer cleared.
  - WAIT without mem_valid_i: set drop=1 and stay in WAIT (one outstanding response is always drained).
  - WAIT with mem_valid_i in the same cycle: discard data, go to IDLE.
  - IDLE or HOLD: go to IDLE.
  - No request is issued in the jump_flag cycle.
- Static prediction (combinational on mem_data_i and pc):
  - JAL (opcode 1101111): pred = pc+imm_J, alt = pc+4.
  - B-type (1100011) with imm_B sign bit = 1 (backward): pred = pc+imm_B, alt = pc+4.
  - B-type forward: pred = pc+4, alt = pc+imm_B.
  - All others, including JALR: pred = pc+4, alt = pc+4.
- Arithmetic is 32-bit wrap-around, with immediates sign-extended per the RV32I formats.
- Latency and throughput:
  - Best case (mem_ready_i in the first IDLE cycle, mem_valid_i one cycle later) gives 3 cycles per instruction: IDLE, WAIT, HOLD.
  - Exactly one outstanding request at any time.

Test Plan:
- Reset then release; memory returns 32'h00000013 (addi) for address 0 -> mem_addr_o=0 on the first request; HOLD shows pc_o=0, inst_o=32'h13, without_prediction_o=4; next request address is 4.
- Backward branch at pc=32'h100, 32'hFE000EE3 (beq, imm=-4) -> next fetch address 32'hFC; without_prediction_o=32'h104.
- Forward JAL at pc=32'h20 with imm=+16 -> next fetch address 32'h30, without_prediction_o=32'h24; forward beq at pc=32'h40 with imm=+8 -> next fetch address 32'h44, without_prediction_o=32'h48.
- stall_signal[2]=1 for 4 cycles while in HOLD -> pc_o, inst_o and without_prediction_o stable, no mem_req_o; release -> IDLE next cycle with a new request.
- jump_flag with target 32'h200 while in WAIT, data returned 2 cycles later -> returned data dropped, no HOLD; next mem_addr_o=32'h200.
- rst asserted mid-WAIT -> outputs zero immediately (asynchronously); a late mem_valid_i is ignored once in IDLE; the first request after reset goes to RESET_PC.
